// File: rtl/ascon_aead_ctrl_if.sv
// Block-stream handshake between the AEAD controller and its data source/tag sink.
interface ascon_aead_ctrl_if;
  logic ad_valid;
  logic ad_last;
  logic ad_ready;
  logic msg_valid;
  logic msg_last;
  logic msg_ready;
  logic tag_valid;
  logic tag_ready;

  // Data source / tag consumer side
  modport master (
    output ad_valid, ad_last, msg_valid, msg_last, tag_ready,
    input  ad_ready, msg_ready, tag_valid
  );

  // Controller side
  modport slave (
    input  ad_valid, ad_last, msg_valid, msg_last, tag_ready,
    output ad_ready, msg_ready, tag_valid
  );
endinterface

// File: rtl/ascon_aead_ctrl.sv
// Ascon AEAD sequencing controller: drives permutation rounds, key/domain XOR
// pulses and the AD/message/tag handshakes for an external Ascon datapath.
module ascon_aead_ctrl #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  no_ad,
  input  logic                  abort,
  ascon_aead_ctrl_if.slave      bus,
  output logic                  load_init,
  output logic                  round_en,
  output logic [3:0]            round_idx,
  output logic                  init_kxor,
  output logic                  dom_sep,
  output logic                  final_kxor,
  output logic                  tag_en,
  output logic                  busy
);

  localparam int unsigned IDX_W      = 4;
  localparam int unsigned LAST_ROUND = 11;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_ROUND);
  localparam logic [IDX_W-1:0] IDX_A0   = IDX_W'(12 - ROUNDS_A);
  localparam logic [IDX_W-1:0] IDX_B0   = IDX_W'(12 - ROUNDS_B);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_INIT_P, ST_INIT_KX, ST_AD_WAIT, ST_AD_P,
    ST_DSEP, ST_MSG_WAIT, ST_MSG_P, ST_FIN_P, ST_FIN_TAG, ST_TAG_OUT
  } state_e;

  typedef struct packed {
    logic load_init;
    logic round_en;
    logic init_kxor;
    logic dom_sep;
    logic final_kxor;
    logic tag_en;
    logic tag_valid;
    logic busy;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             no_ad_q, no_ad_d;
  logic             ad_last_q, ad_last_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             round_last;
  logic             perm_d;

  assign round_last = (idx_q == IDX_LAST);

  // Next state, round counter and registered-output precompute
  always_comb begin
    state_d   = state_q;
    idx_d     = '0;
    no_ad_d   = no_ad_q;
    ad_last_d = ad_last_q;
    ctrl_d    = '0;
    perm_d    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      no_ad_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            no_ad_d = no_ad;
          end
        end
        ST_LOAD: begin
          state_d = ST_INIT_P;
          idx_d   = IDX_A0;
        end
        ST_INIT_P: begin
          if (round_last) state_d = ST_INIT_KX;
          else            idx_d   = idx_q + IDX_W'(1);
        end
        ST_INIT_KX: begin
          state_d = no_ad_q ? ST_DSEP : ST_AD_WAIT;
        end
        ST_AD_WAIT: begin
          if (bus.ad_valid) begin
            state_d   = ST_AD_P;
            idx_d     = IDX_B0;
            ad_last_d = bus.ad_last;
          end
        end
        ST_AD_P: begin
          if (round_last) state_d = ad_last_q ? ST_DSEP : ST_AD_WAIT;
          else            idx_d   = idx_q + IDX_W'(1);
        end
        ST_DSEP: begin
          state_d = ST_MSG_WAIT;
        end
        ST_MSG_WAIT: begin
          if (bus.msg_valid) begin
            // The final block skips p^b and goes straight to finalization
            if (bus.msg_last) begin
              state_d = ST_FIN_P;
              idx_d   = IDX_A0;
            end else begin
              state_d = ST_MSG_P;
              idx_d   = IDX_B0;
            end
          end
        end
        ST_MSG_P: begin
          if (round_last) state_d = ST_MSG_WAIT;
          else            idx_d   = idx_q + IDX_W'(1);
        end
        ST_FIN_P: begin
          if (round_last) state_d = ST_FIN_TAG;
          else            idx_d   = idx_q + IDX_W'(1);
        end
        ST_FIN_TAG: begin
          state_d = ST_TAG_OUT;
        end
        ST_TAG_OUT: begin
          if (bus.tag_ready) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    perm_d = (state_d == ST_INIT_P) || (state_d == ST_AD_P) ||
             (state_d == ST_MSG_P)  || (state_d == ST_FIN_P);

    ctrl_d.load_init  = (state_d == ST_LOAD);
    ctrl_d.round_en   = perm_d;
    ctrl_d.init_kxor  = (state_d == ST_INIT_KX);
    ctrl_d.dom_sep    = (state_d == ST_DSEP);
    ctrl_d.final_kxor = (state_d == ST_FIN_P) && (idx_d == IDX_A0);
    ctrl_d.tag_en     = (state_d == ST_FIN_TAG);
    ctrl_d.tag_valid  = (state_d == ST_TAG_OUT);
    ctrl_d.busy       = (state_d != ST_IDLE);
  end

  // State, counter, flags and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      no_ad_q   <= 1'b0;
      ad_last_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      no_ad_q   <= no_ad_d;
      ad_last_q <= ad_last_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Ready signals are pure state decodes so they never depend on valid
  assign bus.ad_ready  = (state_q == ST_AD_WAIT);
  assign bus.msg_ready = (state_q == ST_MSG_WAIT);
  assign bus.tag_valid = ctrl_q.tag_valid;

  assign load_init  = ctrl_q.load_init;
  assign round_en   = ctrl_q.round_en;
  assign round_idx  = idx_q;
  assign init_kxor  = ctrl_q.init_kxor;
  assign dom_sep    = ctrl_q.dom_sep;
  assign final_kxor = ctrl_q.final_kxor;
  assign tag_en     = ctrl_q.tag_en;
  assign busy       = ctrl_q.busy;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Self-checking bench for ascon_aead_ctrl: per-cycle expected traces are
// assembled from protocol phases (load, p^a, p^b, waits, pulses, tag).
module tb_ascon_aead_ctrl;

  localparam int unsigned RA = 12;
  localparam int unsigned RB = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, no_ad, abort;
  logic load_init, round_en, init_kxor, dom_sep, final_kxor, tag_en, busy;
  logic [3:0] round_idx;

  ascon_aead_ctrl_if bus();

  ascon_aead_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .no_ad(no_ad), .abort(abort),
    .bus(bus),
    .load_init(load_init), .round_en(round_en), .round_idx(round_idx),
    .init_kxor(init_kxor), .dom_sep(dom_sep), .final_kxor(final_kxor),
    .tag_en(tag_en), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       load_init;
    logic       round_en;
    logic [3:0] idx;
    logic       init_kxor;
    logic       dom_sep;
    logic       final_kxor;
    logic       tag_en;
    logic       tag_valid;
    logic       busy;
    logic       ad_ready;
    logic       msg_ready;
  } out_t;

  typedef struct packed {
    logic start;
    logic no_ad;
    logic abort;
    logic ad_valid;
    logic ad_last;
    logic msg_valid;
    logic msg_last;
    logic tag_ready;
  } in_t;

  typedef struct {
    string name;
    int    na, n_ad, n_msg, tag_gap, abort_at;
    int    e_re, e_ad, e_msg, e_tv, e_ds;
  } vec_t;

  out_t exp_q[$];
  in_t  in_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   c_re, c_ad, c_msg, c_tv, c_ds;

  function automatic out_t sample();
    out_t o;
    o.load_init  = load_init;
    o.round_en   = round_en;
    o.idx        = round_idx;
    o.init_kxor  = init_kxor;
    o.dom_sep    = dom_sep;
    o.final_kxor = final_kxor;
    o.tag_en     = tag_en;
    o.tag_valid  = bus.tag_valid;
    o.busy       = busy;
    o.ad_ready   = bus.ad_ready;
    o.msg_ready  = bus.msg_ready;
    return o;
  endfunction

  task automatic drive(input in_t i);
    start         = i.start;
    no_ad         = i.no_ad;
    abort         = i.abort;
    bus.ad_valid  = i.ad_valid;
    bus.ad_last   = i.ad_last;
    bus.msg_valid = i.msg_valid;
    bus.msg_last  = i.msg_last;
    bus.tag_ready = i.tag_ready;
  endtask

  task automatic check(input string name, input int k, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Random junk on every input except abort; used where inputs must be ignored
  function automatic in_t noise();
    in_t n;
    n = in_t'(8'($urandom));
    n.abort = 1'b0;
    return n;
  endfunction

  function automatic out_t busy_o();
    out_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic void push(input in_t i, input out_t o);
    in_q.push_back(i);
    exp_q.push_back(o);
  endfunction

  function automatic void perm(input int r, input bit fin);
    out_t o;
    for (int j = 0; j < r; j++) begin
      o = busy_o();
      o.round_en   = 1'b1;
      o.idx        = 4'(12 - r + j);
      o.final_kxor = fin && (j == 0);
      push(noise(), o);
    end
  endfunction

  // Build one complete operation as parallel stimulus/expectation queues
  function automatic void build(input int na, input int n_ad, input int n_msg,
                                input int ad_gap_max, input int msg_gap_max, input int tag_gap);
    in_t  i;
    out_t o;
    int   gap;
    in_q.delete();
    exp_q.delete();
    i = '0; i.start = 1'b1; i.no_ad = 1'(na);
    push(i, '0);
    o = busy_o(); o.load_init = 1'b1; push(noise(), o);
    perm(RA, 1'b0);
    o = busy_o(); o.init_kxor = 1'b1; push(noise(), o);
    if (na == 0) begin
      for (int a = 0; a < n_ad; a++) begin
        gap = int'($urandom_range(0, ad_gap_max));
        o = busy_o(); o.ad_ready = 1'b1;
        for (int g = 0; g < gap; g++) begin
          i = noise(); i.ad_valid = 1'b0; push(i, o);
        end
        i = noise(); i.ad_valid = 1'b1; i.ad_last = (a == n_ad - 1); push(i, o);
        perm(RB, 1'b0);
      end
    end
    o = busy_o(); o.dom_sep = 1'b1; push(noise(), o);
    for (int m = 0; m < n_msg; m++) begin
      gap = int'($urandom_range(0, msg_gap_max));
      o = busy_o(); o.msg_ready = 1'b1;
      for (int g = 0; g < gap; g++) begin
        i = noise(); i.msg_valid = 1'b0; push(i, o);
      end
      i = noise(); i.msg_valid = 1'b1; i.msg_last = (m == n_msg - 1); push(i, o);
      if (m != n_msg - 1) perm(RB, 1'b0);
    end
    perm(RA, 1'b1);
    o = busy_o(); o.tag_en = 1'b1; push(noise(), o);
    o = busy_o(); o.tag_valid = 1'b1;
    for (int g = 0; g < tag_gap; g++) begin
      i = noise(); i.tag_ready = 1'b0; push(i, o);
    end
    i = noise(); i.tag_ready = 1'b1; push(i, o);
    push('0, '0);
  endfunction

  // Abort in cycle c: that cycle still shows the old state, then idle
  function automatic void apply_abort(input int c);
    in_t t;
    t = in_q[c];
    t.abort = 1'b1;
    in_q[c] = t;
    while (in_q.size() > c + 1) begin
      void'(in_q.pop_back());
      void'(exp_q.pop_back());
    end
    push('0, '0);
  endfunction

  task automatic run(input string name, input int limit);
    out_t got;
    c_re = 0; c_ad = 0; c_msg = 0; c_tv = 0; c_ds = 0;
    for (int k = 0; k < in_q.size() && k < limit; k++) begin
      @(negedge clk);
      got = sample();
      check(name, k, got, exp_q[k]);
      c_re  += int'(got.round_en);
      c_ad  += int'(got.ad_ready);
      c_msg += int'(got.msg_ready);
      c_tv  += int'(got.tag_valid);
      c_ds  += int'(got.dom_sep);
      drive(in_q[k]);
    end
  endtask

  vec_t vecs[7];
  out_t e;

  initial begin
    vecs[0] = '{"basic",      0, 1, 1, 0, -1, 30, 1, 1, 1, 1};
    vecs[1] = '{"two_ad",     0, 2, 1, 0, -1, 36, 2, 1, 1, 1};
    vecs[2] = '{"no_ad_3msg", 1, 0, 3, 0, -1, 36, 0, 3, 1, 1};
    vecs[3] = '{"tag_stall",  0, 1, 2, 5, -1, 36, 1, 2, 6, 1};
    vecs[4] = '{"abort_init", 0, 1, 1, 0,  7,  6, 0, 0, 0, 0};
    vecs[5] = '{"abort_idle", 0, 1, 1, 0,  0,  0, 0, 0, 0, 0};
    vecs[6] = '{"no_ad_1msg", 1, 0, 1, 0, -1, 24, 0, 1, 1, 1};

    drive('0);
    rst_n = 1'b0;
    #12;
    check("reset", 0, sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      build(vecs[v].na, vecs[v].n_ad, vecs[v].n_msg, 0, 0, vecs[v].tag_gap);
      if (vecs[v].abort_at >= 0) apply_abort(vecs[v].abort_at);
      run(vecs[v].name, 1 << 30);
      check_cnt({vecs[v].name, " round_en"},  c_re,  vecs[v].e_re);
      check_cnt({vecs[v].name, " ad_ready"},  c_ad,  vecs[v].e_ad);
      check_cnt({vecs[v].name, " msg_ready"}, c_msg, vecs[v].e_msg);
      check_cnt({vecs[v].name, " tag_valid"}, c_tv,  vecs[v].e_tv);
      check_cnt({vecs[v].name, " dom_sep"},   c_ds,  vecs[v].e_ds);
    end

    for (int s = 0; s < 30; s++) begin
      build(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
            3, 3, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) apply_abort(int'($urandom_range(0, in_q.size() - 2)));
      run("random", 1 << 30);
    end

    // Async reset in the middle of a p^b run, with msg_valid held afterwards
    build(1, 0, 2, 0, 0, 0);
    run("pre_reset", 19);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, sample(), '0);
    drive('0);
    bus.msg_valid = 1'b1;
    bus.msg_last  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_idle", k, sample(), '0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    e = busy_o();
    e.load_init = 1'b1;
    check("start_after_reset", 0, sample(), e);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abort_from_load", 0, sample(), '0);
    drive('0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
